// File: rtl/hdmi_pixel_fifo_if.sv
// Pixel stream bundle between the DVI decoder and the FIFO.
// Carries both handshakes plus occupancy and error status.
interface hdmi_pixel_fifo_if #(
  parameter int CHANNELS      = 3,
  parameter int CHANNEL_WIDTH = 8,
  parameter int DEPTH         = 16
);
  localparam int PW = CHANNELS * CHANNEL_WIDTH;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [PW-1:0] in_pixel;
  logic          in_hsync;
  logic          in_vsync;
  logic          in_de;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] out_pixel;
  logic          out_hsync;
  logic          out_vsync;
  logic          out_de;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          overflow;
  logic          underflow;
  logic [15:0]   drop_count;
  logic          clr_flags;

  modport master (
    output in_pixel, in_hsync, in_vsync, in_de, in_valid,
    output out_ready, clr_flags,
    input  in_ready, out_pixel, out_hsync, out_vsync, out_de,
    input  out_valid, level, almost_full, overflow, underflow,
    input  drop_count
  );

  modport slave (
    input  in_pixel, in_hsync, in_vsync, in_de, in_valid,
    input  out_ready, clr_flags,
    output in_ready, out_pixel, out_hsync, out_vsync, out_de,
    output out_valid, level, almost_full, overflow, underflow,
    output drop_count
  );
endinterface

// File: rtl/hdmi_pixel_fifo.sv
// First-word-fall-through pixel FIFO with sync metadata.
// On overflow it either drops words or flushes to the next frame.
module hdmi_pixel_fifo #(
  parameter int CHANNELS      = 3,
  parameter int CHANNEL_WIDTH = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_LEVEL   = DEPTH - 2,
  parameter int RESYNC        = 1
) (
  input logic              pclk,
  input logic              rstin,
  hdmi_pixel_fifo_if.slave bus
);
  localparam int PW = CHANNELS * CHANNEL_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = PW + 3;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AFULL_LEVEL);

  typedef enum logic {RUN, DISCARD} state_e;

  state_e        state_q;
  logic [WW-1:0] mem_q [DEPTH];
  logic [LW-1:0] wptr_q;
  logic [LW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic          vsync_prev_q;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          run, full, empty;
  logic          in_rdy, out_vld;
  logic          wr, rd, drop, flush, fstart;
  logic [WW-1:0] win;

  // Handshake decode and error-flag next state from registered state.
  always_comb begin
    run     = (state_q == RUN);
    full    = (level_q == FULL_LVL);
    empty   = (level_q == '0);
    in_rdy  = run ? !full : 1'b1;
    out_vld = run && !empty;
    drop    = run && bus.in_valid && full;
    flush   = drop && (RESYNC != 0);
    fstart  = !run && bus.in_valid && bus.in_vsync && !vsync_prev_q;
    wr      = (run && bus.in_valid && !full) || fstart;
    rd      = out_vld && bus.out_ready;
    win     = {bus.in_vsync, bus.in_hsync, bus.in_de, bus.in_pixel};
    ovf_d   = bus.clr_flags ? 1'b0 : ovf_q;
    udf_d   = bus.clr_flags ? 1'b0 : udf_q;
    cnt_d   = bus.clr_flags ? 16'd0 : cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (cnt_d != 16'hFFFF) cnt_d = cnt_d + 16'd1;
    end
    if (run && bus.out_ready && !out_vld) udf_d = 1'b1;
  end

  // Storage, pointers, resync state machine and error registers.
  always_ff @(posedge pclk or posedge rstin) begin
    if (rstin) begin
      state_q      <= RUN;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      vsync_prev_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      cnt_q        <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      cnt_q <= cnt_d;
      if (bus.in_valid) vsync_prev_q <= bus.in_vsync;
      if (wr) mem_q[wptr_q[AW-1:0]] <= win;
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
        state_q <= DISCARD;
      end else begin
        if (wr) wptr_q <= wptr_q + 1'b1;
        if (rd) rptr_q <= rptr_q + 1'b1;
        level_q <= level_q + LW'(wr) - LW'(rd);
        if (fstart) state_q <= RUN;
      end
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = out_vld;
  assign {bus.out_vsync, bus.out_hsync, bus.out_de, bus.out_pixel}
    = mem_q[rptr_q[AW-1:0]];
  assign bus.level       = level_q;
  assign bus.almost_full = (level_q >= AF_LVL);
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  assign bus.drop_count  = cnt_q;
endmodule

// File: tb/tb_hdmi_pixel_fifo.sv
// Bench for hdmi_pixel_fifo: drop mode and resync mode side by side.
// Both instances see the same stimulus and are checked against queue models.
module tb_hdmi_pixel_fifo;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix = '0;
  logic        hs = 0, vs = 0, de = 0, iv = 0, ordy = 0, clr = 0;

  int n_cmp = 0;
  int n_err = 0;

  hdmi_pixel_fifo_if #(.CHANNELS(3), .CHANNEL_WIDTH(8), .DEPTH(D)) ia();
  hdmi_pixel_fifo_if #(.CHANNELS(3), .CHANNEL_WIDTH(8), .DEPTH(D)) ib();

  assign ia.in_pixel  = pix;
  assign ia.in_hsync  = hs;
  assign ia.in_vsync  = vs;
  assign ia.in_de     = de;
  assign ia.in_valid  = iv;
  assign ia.out_ready = ordy;
  assign ia.clr_flags = clr;
  assign ib.in_pixel  = pix;
  assign ib.in_hsync  = hs;
  assign ib.in_vsync  = vs;
  assign ib.in_de     = de;
  assign ib.in_valid  = iv;
  assign ib.out_ready = ordy;
  assign ib.clr_flags = clr;

  hdmi_pixel_fifo #(.DEPTH(D), .RESYNC(0)) dut_a (
    .pclk(clk), .rstin(rst), .bus(ia)
  );
  hdmi_pixel_fifo #(.DEPTH(D), .RESYNC(1)) dut_b (
    .pclk(clk), .rstin(rst), .bus(ib)
  );

  always #5 clk = ~clk;

  // reference models: index 0 = drop mode, 1 = resync mode
  logic [26:0] q0[$];
  logic [26:0] q1[$];
  bit mdisc[2];
  bit mvp[2];
  bit movf[2];
  bit mudf[2];
  int mcnt[2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [26:0] qhead(input int m);
    if (m == 0) return (q0.size() > 0) ? q0[0] : 27'd0;
    return (q1.size() > 0) ? q1[0] : 27'd0;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      mdisc[m] = 0; mvp[m] = 0; movf[m] = 0; mudf[m] = 0; mcnt[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    int sz;
    bit full, disc, ovld, drop, fst;
    logic [26:0] w;
    sz   = qsize(m);
    full = (sz == D);
    disc = mdisc[m];
    ovld = !disc && sz > 0;
    drop = !disc && iv && full;
    fst  = disc && iv && vs && !mvp[m];
    w    = {vs, hs, de, pix};
    if (clr) begin movf[m] = 0; mudf[m] = 0; mcnt[m] = 0; end
    if (drop) begin
      movf[m] = 1;
      if (mcnt[m] < 65535) mcnt[m]++;
    end
    if (!disc && ordy && !ovld) mudf[m] = 1;
    if (iv) mvp[m] = vs;
    if (drop && m == 1) begin
      q1.delete();
      mdisc[m] = 1;
    end else begin
      if (ovld && ordy) begin
        if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if ((!disc && iv && !full) || fst) begin
        if (m == 0) q0.push_back(w); else q1.push_back(w);
      end
      if (fst) mdisc[m] = 0;
    end
  endtask

  task automatic check_dut(input int m);
    logic rdy, vld, af, ov, uf;
    logic [3:0] lv;
    logic [15:0] dc;
    logic [26:0] hd;
    string p;
    int sz;
    bit evld;
    p = (m == 0) ? "a" : "b";
    if (m == 0) begin
      rdy = ia.in_ready; vld = ia.out_valid; af = ia.almost_full;
      ov = ia.overflow; uf = ia.underflow; lv = ia.level;
      dc = ia.drop_count;
      hd = {ia.out_vsync, ia.out_hsync, ia.out_de, ia.out_pixel};
    end else begin
      rdy = ib.in_ready; vld = ib.out_valid; af = ib.almost_full;
      ov = ib.overflow; uf = ib.underflow; lv = ib.level;
      dc = ib.drop_count;
      hd = {ib.out_vsync, ib.out_hsync, ib.out_de, ib.out_pixel};
    end
    sz = qsize(m);
    evld = !mdisc[m] && sz > 0;
    chk({p, ".in_ready"}, rdy, mdisc[m] ? 1'b1 : (sz < D));
    chk({p, ".out_valid"}, vld, evld);
    chk({p, ".level"}, lv, sz);
    chk({p, ".almost_full"}, af, sz >= D - 2);
    chk({p, ".overflow"}, ov, movf[m]);
    chk({p, ".underflow"}, uf, mudf[m]);
    chk({p, ".drop_count"}, dc, mcnt[m]);
    if (evld) chk({p, ".head"}, hd, qhead(m));
  endtask

  task automatic step(input logic v, input logic [23:0] p,
                      input logic vs_i, input logic hs_i,
                      input logic de_i, input logic r, input logic c);
    check_dut(0);
    check_dut(1);
    iv = v; pix = p; vs = vs_i; hs = hs_i; de = de_i; ordy = r; clr = c;
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(0, 24'h0, 0, 0, 0, r, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.a.in_ready", ia.in_ready, 1);
    chk("rst.b.out_valid", ib.out_valid, 0);
    chk("rst.a.out_pixel", ia.out_pixel, 0);
    chk("rst.a.level", ia.level, 0);
    rst = 1'b0;
    @(negedge clk);

    // five words in order, fall-through on first
    for (int i = 0; i < 5; i++) begin
      step(1, 24'h010203 + 24'h010101 * i, 0, i[0], 1, 0, 0);
      if (i == 0) begin
        chk("fwft.valid", ia.out_valid, 1);
        chk("fwft.pixel", ia.out_pixel, 24'h010203);
      end
    end
    chk("five.level", ia.level, 5);
    idle(5, 1);
    chk("drain.level", ia.level, 0);

    // fill to full, almost_full at 6
    for (int i = 0; i < D; i++) begin
      step(1, 24'hA00000 + i, 0, 0, 1, 0, 0);
      if (i == 5) chk("afull.at6", ia.almost_full, 1);
    end
    chk("full.in_ready", ia.in_ready, 0);
    chk("full.level", ia.level, D);

    // three extra words: drops vs flush
    for (int i = 0; i < 3; i++) step(1, 24'hEE0000 + i, 0, 0, 1, 0, 0);
    chk("a.drop3", ia.drop_count, 3);
    chk("a.ovf", ia.overflow, 1);
    chk("a.head_kept", ia.out_pixel, 24'hA00000);
    chk("b.flush_level", ib.level, 0);
    chk("b.flush_valid", ib.out_valid, 0);
    chk("b.drop1", ib.drop_count, 1);

    // write and read together at full: write refused
    step(1, 24'hEF0000, 0, 0, 1, 1, 0);
    chk("a.full_rw_level", ia.level, D - 1);

    // discard absorbs vsync-low words, no underflow there
    for (int i = 0; i < 10; i++) step(1, 24'h300000 + i, 0, 0, 1, 1, 0);
    chk("b.drop_stays", ib.drop_count, 1);
    chk("b.no_udf", ib.underflow, 0);
    step(1, 24'h5A5A5A, 1, 0, 0, 0, 0);
    chk("b.resync_valid", ib.out_valid, 1);
    chk("b.resync_vsync", ib.out_vsync, 1);
    chk("b.resync_pix", ib.out_pixel, 24'h5A5A5A);

    step(0, 24'h0, 1, 0, 0, 0, 1);
    chk("a.clr_ovf", ia.overflow, 0);
    chk("a.clr_cnt", ia.drop_count, 0);
    idle(10, 1);
    chk("a.udf", ia.underflow, 1);
    step(0, 24'h0, 0, 0, 0, 0, 1);

    // async reset with words inside
    for (int i = 0; i < 4; i++) step(1, 24'h440000 + i, 0, 0, 1, 0, 0);
    chk("pre_rst.level", ia.level, 4);
    rst = 1'b1;
    #1;
    chk("mid_rst.a.level", ia.level, 0);
    chk("mid_rst.b.valid", ib.out_valid, 0);
    chk("mid_rst.a.udf", ia.underflow, 0);
    model_reset();
    iv = 0; ordy = 0; clr = 0; vs = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // random stream against the models
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 24'($urandom),
           $urandom_range(0, 15) == 0, 1'($urandom),
           1'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 60) == 0);
    end
    idle(12, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
